// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between the EX/MEM and MEM/WB registers.
// Latency: non-memory ops pass in 1 cycle; loads/stores add one cycle per SRAM handshake wait.
// Backpressure: mem_allowin drops until the SRAM access completes and writeback can accept.
// Optional feature: define MEM_ALE_CHECK_EN to flag misaligned half/word accesses.
module mem_stage #(
  parameter logic [31:0] WB_RESET_PC = 32'h1bfffffc
) (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM pipeline register
  input  logic        mem_valid,
  output logic        mem_allowin,
  input  logic        mem_ref_we,
  input  logic        mem_dram_re,
  input  logic        mem_dram_we,
  input  logic        mem_res_from_dram,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_dram_waddr,
  input  logic [31:0] mem_dram_wdata,
  input  logic [31:0] mem_pc,
  input  logic [1:0]  mem_rdram_num,
  input  logic [1:0]  mem_wdram_num,
  input  logic        mem_rdram_need_signed_extend,
  input  logic        mem_rdram_need_zero_extend,
  // data SRAM
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [3:0]  data_sram_wstrb,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  // MEM/WB pipeline register
  input  logic        wb_allowin,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic        wb_rf_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_rf_wdata,
  output logic        wb_ale,
  // forwarding to decode
  output logic [4:0]  fwd_rd,
  output logic        fwd_data_ok,
  output logic [31:0] fwd_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] ld_buf_q;

  logic        wb_valid_q;
  logic [31:0] wb_pc_q;
  logic        wb_rf_we_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_rf_wdata_q;

  logic        memop;
  logic        ale;
  logic        req_en;
  logic        data_done;
  logic        ms_ready_go;
  logic [1:0]  ld_a;
  logic [1:0]  st_a;
  logic [31:0] ld_raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_aligned;
  logic [31:0] res_data;
  logic        rf_we_eff;

  // Zero-extension is the fallback whenever signed extension is not requested,
  // so the explicit zero-extend flag carries no extra information.
  logic        unused_zero_ext;
  assign unused_zero_ext = mem_rdram_need_zero_extend;

  assign memop = mem_valid & (mem_dram_re | mem_dram_we);
  assign ld_a  = mem_alu_result[1:0];
  assign st_a  = mem_dram_waddr[1:0];

`ifdef MEM_ALE_CHECK_EN
  logic [1:0] acc_num;
  logic [1:0] acc_a;
  assign acc_num = mem_dram_we ? mem_wdram_num : mem_rdram_num;
  assign acc_a   = mem_dram_we ? st_a : ld_a;
  // Half needs 2-byte alignment, word (10 or 11) needs 4-byte alignment.
  assign ale = memop & (((acc_num == 2'b01) & acc_a[0]) |
                        (acc_num[1] & (acc_a != 2'b00)));
`else
  assign ale = 1'b0;
`endif

  assign req_en    = memop & ~ale;
  assign data_done = (state_q == S_WAIT) & data_sram_data_ok;

  // Single-cycle handshake FSM; data_ok is only honoured in WAIT, which makes a
  // late response after reset or a stray pulse while idle harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ld_buf_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_en) begin
            state_q <= data_sram_addr_ok ? S_WAIT : S_REQ;
          end
        end
        S_REQ: begin
          if (data_sram_addr_ok) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_sram_data_ok) begin
            ld_buf_q <= data_sram_rdata;
            state_q  <= wb_allowin ? S_IDLE : S_DONE;
          end
        end
        S_DONE: begin
          if (wb_allowin) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Request is gated by reset so it drops the moment reset is asserted even
  // while the upstream register still presents a memory op.
  assign data_sram_req = rst & (((state_q == S_IDLE) & req_en) | (state_q == S_REQ));
  assign data_sram_wr  = mem_dram_we;
  assign data_sram_addr = mem_dram_we ? mem_dram_waddr : mem_alu_result;

  // Store byte-lane strobe and lane-replicated write data
  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = mem_dram_wdata;
    if (mem_dram_we) begin
      unique case (mem_wdram_num)
        2'b00: begin
          data_sram_wstrb = 4'b0001 << st_a;
          data_sram_wdata = {4{mem_dram_wdata[7:0]}};
        end
        2'b01: begin
          data_sram_wstrb = 4'b0011 << {st_a[1], 1'b0};
          data_sram_wdata = {2{mem_dram_wdata[15:0]}};
        end
        default: begin
          data_sram_wstrb = 4'hf;
          data_sram_wdata = mem_dram_wdata;
        end
      endcase
    end
  end

  // Load data comes straight from the SRAM on the data_ok cycle and from the
  // buffer once parked in DONE.
  assign ld_raw = (state_q == S_DONE) ? ld_buf_q : data_sram_rdata;

  // Lane selection for sub-word loads
  always_comb begin
    ld_byte = ld_raw[7:0];
    unique case (ld_a)
      2'b00:   ld_byte = ld_raw[7:0];
      2'b01:   ld_byte = ld_raw[15:8];
      2'b10:   ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_a[1] ? ld_raw[31:16] : ld_raw[15:0];
  end

  // Sign or zero extension; signed wins when both flags are set
  always_comb begin
    ld_aligned = ld_raw;
    unique case (mem_rdram_num)
      2'b00:   ld_aligned = {{24{mem_rdram_need_signed_extend & ld_byte[7]}}, ld_byte};
      2'b01:   ld_aligned = {{16{mem_rdram_need_signed_extend & ld_half[15]}}, ld_half};
      default: ld_aligned = ld_raw;
    endcase
  end

  assign res_data    = mem_res_from_dram ? ld_aligned : mem_alu_result;
  assign rf_we_eff   = mem_ref_we & (mem_rd != 5'd0) & ~ale;

  assign ms_ready_go = ~memop | ale | data_done | (state_q == S_DONE);
  assign mem_allowin = ~mem_valid | (ms_ready_go & wb_allowin);

  assign fwd_rd      = (mem_valid & mem_ref_we) ? mem_rd : 5'd0;
  assign fwd_data_ok = ~mem_res_from_dram | data_done | (state_q == S_DONE);
  assign fwd_data    = res_data;

  // MEM/WB register: advances whenever writeback accepts, holds otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q    <= 1'b0;
      wb_pc_q       <= WB_RESET_PC;
      wb_rf_we_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_rf_wdata_q <= '0;
    end else if (wb_allowin) begin
      wb_valid_q    <= mem_valid & ms_ready_go;
      wb_pc_q       <= mem_pc;
      wb_rf_we_q    <= rf_we_eff;
      wb_rd_q       <= mem_rd;
      wb_rf_wdata_q <= res_data;
    end
  end

`ifdef MEM_ALE_CHECK_EN
  logic wb_ale_q;
  // Misalignment flag travels alongside the payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ale_q <= 1'b0;
    end else if (wb_allowin) begin
      wb_ale_q <= ale;
    end
  end
  assign wb_ale = wb_ale_q;
`else
  assign wb_ale = 1'b0;
`endif

  assign wb_valid    = wb_valid_q;
  assign wb_pc       = wb_pc_q;
  assign wb_rf_we    = wb_rf_we_q;
  assign wb_rd       = wb_rd_q;
  assign wb_rf_wdata = wb_rf_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: table-driven instructions with a cycle-level SRAM
// responder, plus a writeback scoreboard and a hand-written reset sequence.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_allowin;
  logic        mem_ref_we, mem_dram_re, mem_dram_we, mem_res_from_dram;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result, mem_dram_waddr, mem_dram_wdata, mem_pc;
  logic [1:0]  mem_rdram_num, mem_wdram_num;
  logic        mem_rdram_need_signed_extend, mem_rdram_need_zero_extend;
  logic        data_sram_req, data_sram_wr;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rf_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rf_wdata;
  logic        wb_ale;
  logic [4:0]  fwd_rd;
  logic        fwd_data_ok;
  logic [31:0] fwd_data;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_allowin(mem_allowin),
    .mem_ref_we(mem_ref_we), .mem_dram_re(mem_dram_re), .mem_dram_we(mem_dram_we),
    .mem_res_from_dram(mem_res_from_dram), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_dram_waddr(mem_dram_waddr),
    .mem_dram_wdata(mem_dram_wdata), .mem_pc(mem_pc),
    .mem_rdram_num(mem_rdram_num), .mem_wdram_num(mem_wdram_num),
    .mem_rdram_need_signed_extend(mem_rdram_need_signed_extend),
    .mem_rdram_need_zero_extend(mem_rdram_need_zero_extend),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
    .wb_rd(wb_rd), .wb_rf_wdata(wb_rf_wdata), .wb_ale(wb_ale),
    .fwd_rd(fwd_rd), .fwd_data_ok(fwd_data_ok), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        re, we, rfd, rf_we;
    logic [4:0]  rd;
    logic [31:0] alu, waddr, wdata;
    logic [1:0]  rnum, wnum;
    logic        sext, zext;
    logic [31:0] rdata;
    int          addr_dly, data_dly, wb_stall;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_sdata;
    logic        exp_rf_we;
    logic [31:0] exp_wdata;
    int          exp_cycles;
    logic        exp_ale;
    int          exp_nreq;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        ale;
  } wb_exp_t;

  wb_exp_t sb[$];
  vec_t    vec[11];
  int      n_cmp = 0;
  int      n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
      input logic [31:0] pc, input logic re, input logic we, input logic rfd,
      input logic rf_we, input logic [4:0] rd, input logic [31:0] alu,
      input logic [31:0] waddr, input logic [31:0] wdata, input logic [1:0] rnum,
      input logic [1:0] wnum, input logic sext, input logic zext, input logic [31:0] rdata,
      input int addr_dly, input int data_dly, input int wb_stall,
      input logic [31:0] exp_addr, input logic [3:0] exp_strb, input logic [31:0] exp_sdata,
      input logic exp_rf_we, input logic [31:0] exp_wdata, input int exp_cycles,
      input logic exp_ale, input int exp_nreq);
    vec_t v;
    v.pc = pc; v.re = re; v.we = we; v.rfd = rfd; v.rf_we = rf_we; v.rd = rd;
    v.alu = alu; v.waddr = waddr; v.wdata = wdata; v.rnum = rnum; v.wnum = wnum;
    v.sext = sext; v.zext = zext; v.rdata = rdata;
    v.addr_dly = addr_dly; v.data_dly = data_dly; v.wb_stall = wb_stall;
    v.exp_addr = exp_addr; v.exp_strb = exp_strb; v.exp_sdata = exp_sdata;
    v.exp_rf_we = exp_rf_we; v.exp_wdata = exp_wdata; v.exp_cycles = exp_cycles;
    v.exp_ale = exp_ale; v.exp_nreq = exp_nreq;
    return v;
  endfunction

  // Writeback consumer: an entry is retired when wb_valid meets wb_allowin
  always @(negedge clk) begin
    if (rst && wb_valid && wb_allowin) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected_valid", {31'd0, wb_valid}, 32'd0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_rf_we", {31'd0, wb_rf_we}, {31'd0, e.rf_we});
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_ale", {31'd0, wb_ale}, {31'd0, e.ale});
        if (e.chk_wdata) chk("wb_rf_wdata", wb_rf_wdata, e.wdata);
      end
    end
  end

  // Runs one instruction through the stage, acting as the SRAM and as the
  // writeback stage's allowin; entered and left just after a rising edge.
  task automatic issue(input vec_t v);
    int          acc_cyc, req_n;
    bit          accepted, got_data, left, pend, memop;
    logic [31:0] p_addr, p_sdata;
    logic [3:0]  p_strb;
    wb_exp_t     e;
    mem_pc = v.pc; mem_dram_re = v.re; mem_dram_we = v.we; mem_res_from_dram = v.rfd;
    mem_ref_we = v.rf_we; mem_rd = v.rd; mem_alu_result = v.alu; mem_dram_waddr = v.waddr;
    mem_dram_wdata = v.wdata; mem_rdram_num = v.rnum; mem_wdram_num = v.wnum;
    mem_rdram_need_signed_extend = v.sext; mem_rdram_need_zero_extend = v.zext;
    mem_valid = 1'b1;
    e.pc = v.pc; e.rf_we = v.exp_rf_we; e.rd = v.rd; e.wdata = v.exp_wdata;
    e.chk_wdata = !v.exp_ale; e.ale = v.exp_ale;
    sb.push_back(e);
    memop = v.re | v.we;
    acc_cyc = 0; req_n = 0; accepted = 0; got_data = 0; left = 0; pend = 0;
    p_addr = '0; p_sdata = '0; p_strb = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      wb_allowin = (cyc >= v.wb_stall);
      data_sram_addr_ok = !accepted && (cyc >= v.addr_dly);
      data_sram_data_ok = accepted && !got_data && (cyc >= acc_cyc + 1 + v.data_dly);
      data_sram_rdata = data_sram_data_ok ? v.rdata : 32'hBAD0BAD0;
      @(negedge clk);
      if (memop && !v.exp_ale && !accepted) chk("req_held", {31'd0, data_sram_req}, 32'd1);
      if (v.exp_ale) chk("ale_no_req", {31'd0, data_sram_req}, 32'd0);
      if (pend) begin
        chk("req_addr_stable", data_sram_addr, p_addr);
        chk("req_strb_stable", {28'd0, data_sram_wstrb}, {28'd0, p_strb});
        chk("req_wdata_stable", data_sram_wdata, p_sdata);
      end
      pend = data_sram_req && !data_sram_addr_ok;
      p_addr = data_sram_addr; p_strb = data_sram_wstrb; p_sdata = data_sram_wdata;
      if (data_sram_req && data_sram_addr_ok) begin
        accepted = 1; acc_cyc = cyc; req_n++;
        chk("sram_addr", data_sram_addr, v.exp_addr);
        chk("sram_wr", {31'd0, data_sram_wr}, {31'd0, v.we});
        if (v.we) begin
          chk("sram_wstrb", {28'd0, data_sram_wstrb}, {28'd0, v.exp_strb});
          chk("sram_wdata", data_sram_wdata, v.exp_sdata);
        end
      end
      if (data_sram_data_ok) got_data = 1;
      if (cyc == 0) begin
        chk("fwd_rd", {27'd0, fwd_rd}, v.rf_we ? {27'd0, v.rd} : 32'd0);
        chk("fwd_data_ok_c0", {31'd0, fwd_data_ok}, {31'd0, !v.rfd});
      end else if (cyc == v.exp_cycles - 1) begin
        chk("fwd_data_ok_end", {31'd0, fwd_data_ok}, 32'd1);
        chk("fwd_data", fwd_data, v.exp_wdata);
      end
      chk("mem_allowin", {31'd0, mem_allowin}, {31'd0, cyc == v.exp_cycles - 1});
      left = mem_allowin;
      @(posedge clk); #1;
      if (left) break;
    end
    if (!left) chk("issue_timeout", 32'd0, 32'd1);
    chk("req_count", req_n, v.exp_nreq);
    mem_valid = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; wb_allowin = 1'b1;
  endtask

  initial begin
    rst = 1'b0; mem_valid = 1'b0; mem_ref_we = 0; mem_dram_re = 0; mem_dram_we = 0;
    mem_res_from_dram = 0; mem_rd = 0; mem_alu_result = 0; mem_dram_waddr = 0;
    mem_dram_wdata = 0; mem_pc = 0; mem_rdram_num = 0; mem_wdram_num = 0;
    mem_rdram_need_signed_extend = 0; mem_rdram_need_zero_extend = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0; wb_allowin = 1'b1;

    //        pc            re we rfd rfwe rd     alu           waddr         wdata         rn     wn     sx zx rdata         ad dd ws  e_addr        strb   sdata         rfwe e_wdata       cyc ale nreq
    vec[0] = mk(32'h1c000000, 0, 0, 0, 1, 5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        2'b00, 2'b00, 0, 0, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        1, 32'hDEADBEEF, 1, 0, 0);
    vec[1] = mk(32'h1c000004, 1, 0, 1, 1, 5'd7,  32'h00001003, 32'h0,        32'h0,        2'b00, 2'b00, 1, 0, 32'h80FF0000, 0, 0, 0, 32'h00001003, 4'h0, 32'h0,        1, 32'hFFFFFF80, 2, 0, 1);
    vec[2] = mk(32'h1c000008, 0, 1, 0, 0, 5'd0,  32'h00002002, 32'h00002002, 32'h1234ABCD, 2'b00, 2'b01, 0, 0, 32'h0,        0, 0, 0, 32'h00002002, 4'hC, 32'hABCDABCD, 0, 32'h00002002, 2, 0, 1);
    vec[3] = mk(32'h1c00000c, 1, 0, 1, 1, 5'd9,  32'h00003000, 32'h0,        32'h0,        2'b10, 2'b00, 0, 0, 32'hCAFEF00D, 3, 0, 0, 32'h00003000, 4'h0, 32'h0,        1, 32'hCAFEF00D, 5, 0, 1);
    vec[4] = mk(32'h1c000010, 1, 0, 1, 1, 5'd10, 32'h00001002, 32'h0,        32'h0,        2'b01, 2'b00, 0, 1, 32'h87654321, 0, 2, 0, 32'h00001002, 4'h0, 32'h0,        1, 32'h00008765, 4, 0, 1);
    vec[5] = mk(32'h1c000014, 1, 0, 1, 1, 5'd11, 32'h00001000, 32'h0,        32'h0,        2'b01, 2'b00, 1, 0, 32'h00008001, 0, 0, 3, 32'h00001000, 4'h0, 32'h0,        1, 32'hFFFF8001, 4, 0, 1);
    vec[6] = mk(32'h1c000018, 1, 0, 1, 1, 5'd12, 32'h00001001, 32'h0,        32'h0,        2'b00, 2'b00, 1, 1, 32'h1234A578, 0, 0, 0, 32'h00001001, 4'h0, 32'h0,        1, 32'hFFFFFFA5, 2, 0, 1);
    vec[7] = mk(32'h1c00001c, 0, 1, 0, 0, 5'd0,  32'h00002001, 32'h00002001, 32'h000000EF, 2'b00, 2'b00, 0, 0, 32'h0,        0, 0, 0, 32'h00002001, 4'h2, 32'hEFEFEFEF, 0, 32'h00002001, 2, 0, 1);
    vec[8] = mk(32'h1c000020, 0, 1, 0, 0, 5'd0,  32'h00002004, 32'h00002004, 32'h11223344, 2'b00, 2'b10, 0, 0, 32'h0,        1, 1, 0, 32'h00002004, 4'hF, 32'h11223344, 0, 32'h00002004, 4, 0, 1);
`ifdef MEM_ALE_CHECK_EN
    vec[9] = mk(32'h1c000024, 1, 0, 1, 1, 5'd13, 32'h00001002, 32'h0,        32'h0,        2'b10, 2'b00, 0, 0, 32'h55667788, 0, 0, 0, 32'h00001002, 4'h0, 32'h0,        0, 32'h0,        1, 1, 0);
`else
    vec[9] = mk(32'h1c000024, 1, 0, 1, 1, 5'd13, 32'h00001002, 32'h0,        32'h0,        2'b10, 2'b00, 0, 0, 32'h55667788, 0, 0, 0, 32'h00001002, 4'h0, 32'h0,        1, 32'h55667788, 2, 0, 1);
`endif
    vec[10] = mk(32'h1c000028, 0, 0, 0, 1, 5'd0, 32'h12345678, 32'h0,        32'h0,        2'b00, 2'b00, 0, 0, 32'h0,        0, 0, 2, 32'h0,        4'h0, 32'h0,        0, 32'h12345678, 3, 0, 0);

    // Reset state, with a load presented so the request gating is visible
    repeat (2) @(negedge clk);
    mem_valid = 1'b1; mem_dram_re = 1'b1; mem_alu_result = 32'h00001000;
    #1;
    chk("rst_req", {31'd0, data_sram_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_pc", wb_pc, 32'h1bfffffc);
    chk("rst_wb_rf_we", {31'd0, wb_rf_we}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_rf_wdata", wb_rf_wdata, 32'd0);
    chk("rst_wb_ale", {31'd0, wb_ale}, 32'd0);
    mem_valid = 1'b0; mem_dram_re = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) issue(vec[i]);

    // Reset while in WAIT, then a late data_ok must not produce a writeback
    mem_pc = 32'h1c000100; mem_dram_re = 1'b1; mem_dram_we = 1'b0; mem_res_from_dram = 1'b1;
    mem_ref_we = 1'b1; mem_rd = 5'd14; mem_alu_result = 32'h00004000; mem_rdram_num = 2'b10;
    mem_valid = 1'b1; data_sram_addr_ok = 1'b1; wb_allowin = 1'b1;
    @(negedge clk);
    chk("wr_req", {31'd0, data_sram_req}, 32'd1);
    @(posedge clk); #1 data_sram_addr_ok = 1'b0;
    @(negedge clk);
    chk("wr_wait_allowin", {31'd0, mem_allowin}, 32'd0);
    #1 rst = 1'b0;
    #1 chk("wr_req_drop", {31'd0, data_sram_req}, 32'd0);
    mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 data_sram_data_ok = 1'b1; data_sram_rdata = 32'h77777777;
    @(posedge clk); #1 data_sram_data_ok = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wr_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    @(posedge clk); #1;
    // A fresh load must start from IDLE and complete normally
    issue(vec[1]);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
